// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter: FSM encodings,
// requester count and priority pointer width.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_N     = 4;
    localparam int ARB_PTR_W = 2;

endpackage : arb_pkg

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority picker: returns the first asserted request
// at or after the start index, wrapping modulo four.
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_PTR_W-1:0] start,
    output logic                 valid,
    output logic [ARB_PTR_W-1:0] idx
);

    logic [ARB_PTR_W-1:0] w_cand;

    // Natural 2-bit wrap of start+i gives the circular search order.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int i = 0; i < ARB_N; i++) begin
            w_cand = start + ARB_PTR_W'(i);
            if (!valid && req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule : rr_pick_4

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter holding a registered grant until done.
// Optional forced release after TIMEOUT grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ARB_N-1:0]     req,
    input  logic                 done,
    output logic [ARB_N-1:0]     grant,
    output logic [ARB_PTR_W-1:0] grant_id,
    output logic                 busy,
    output logic                 err
);

    arb_state_t           r_state;
    logic [ARB_PTR_W-1:0] r_ptr;
    logic [ARB_N-1:0]     r_grant;
    logic [ARB_PTR_W-1:0] r_grantId;
    logic                 r_busy;
    logic                 r_err;

    logic [ARB_PTR_W-1:0] w_start;
    logic                 w_valid;
    logic [ARB_PTR_W-1:0] w_idx;
    logic                 w_timeout;
    logic                 w_release;

    if (TIMEOUT < 1) begin : g_timeoutCheck
        $error("rr_arbiter_4: TIMEOUT must be at least 1");
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_holdCnt;

    // Counter reads k-1 during the k-th grant cycle, so the release edge ends cycle TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst || r_state == ARB_IDLE || w_release) begin
            r_holdCnt <= '0;
        end else begin
            r_holdCnt <= r_holdCnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == ARB_GRANT) && !done
                       && (r_holdCnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_release = (r_state == ARB_GRANT) && (done || w_timeout);
    assign w_start   = (r_state == ARB_GRANT) ? r_grantId + ARB_PTR_W'(1) : r_ptr;

    rr_pick_4 u_pick (
        .req   (req),
        .start (w_start),
        .valid (w_valid),
        .idx   (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_grantId <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= ((r_state == ARB_IDLE) && done) || w_timeout;
            if (r_state == ARB_IDLE || w_release) begin
                if (w_release) begin
                    r_ptr <= r_grantId + ARB_PTR_W'(1);
                end
                if (w_valid) begin
                    r_state   <= ARB_GRANT;
                    r_grant   <= ARB_N'(1) << w_idx;
                    r_grantId <= w_idx;
                    r_busy    <= 1'b1;
                end else begin
                    r_state   <= ARB_IDLE;
                    r_grant   <= '0;
                    r_grantId <= '0;
                    r_busy    <= 1'b0;
                end
            end
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grantId;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule : rr_arbiter_4

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: expectations are queued as stimulus is
// driven and compared one cycle later. Define ARB_TIMEOUT_EN to cover forced release.
module tb_rr_arbiter_4;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] id;
        logic       busy;
        logic       err;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic       done;
        exp_t       exp;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       err;

    int   nChecks = 0;
    int   nFails  = 0;
    exp_t sb[$];

    rr_arbiter_4 #(.TIMEOUT(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge, and outputs are sampled there too.
    task automatic applyStimulus(input logic r, input logic [3:0] q, input logic d, input exp_t e);
        rst  = r;
        req  = q;
        done = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Independent reference: rotate the request vector so start lands at bit 0.
    function automatic logic [1:0] mdlPick(input logic [3:0] r, input logic [1:0] s, output logic v);
        logic [7:0] dbl;
        logic [1:0] res;
        dbl = {r, r} >> s;
        v   = 1'b0;
        res = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (dbl[i]) begin
                v   = 1'b1;
                res = s + 2'(i);
            end
        end
        return res;
    endfunction

    task automatic test_reset();
        exp_t e;
        exp_t got;
        applyStimulus(1'b1, 4'b0000, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) applyStimulus(1'b0, 4'b0000, 1'b0, '0);
            e   = sb.pop_front();
            got = {grant, grant_id, busy, err};
            nChecks++;
            if (got !== e) begin
                nFails++;
                $display("[TB] FAIL reset_idle[%0d]: got %b, expected %b", i, got, e);
            end
        end
    endtask

    task automatic test_pattern();
        stim_t tbl[7];
        exp_t  e;
        exp_t  got;
        tbl[0] = {1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[1] = {1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[2] = {1'b0, 4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[3] = {1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[4] = {1'b0, 4'b1110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[5] = {1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[6] = {1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].req, tbl[i].done, tbl[i].exp);
            e   = sb.pop_front();
            got = {grant, grant_id, busy, err};
            nChecks++;
            if (got !== e) begin
                nFails++;
                $display("[TB] FAIL pattern[%0d]: got %b, expected %b", i, got, e);
            end
        end
    endtask

    task automatic test_round_robin();
        exp_t       e;
        exp_t       got;
        logic       mBusy = 1'b0;
        logic [1:0] mHold = 2'd0;
        logic [1:0] mPtr  = 2'd0;
        logic       v;
        logic       d;
        int         mCnt  = 0;
        int         order[$];
        int         want[5] = '{0, 1, 2, 3, 0};
        applyStimulus(1'b1, 4'b0000, 1'b0, '0);
        void'(sb.pop_front());
        for (int c = 0; c < 15; c++) begin
            d = mBusy && (mCnt == 2);
            if (!mBusy) begin
                mHold = mdlPick(4'b1111, mPtr, v);
                mBusy = v;
                mCnt  = 0;
                order.push_back(int'(mHold));
            end else if (d) begin
                mPtr  = mHold + 2'd1;
                mHold = mdlPick(4'b1111, mPtr, v);
                mCnt  = 0;
                order.push_back(int'(mHold));
            end else begin
                mCnt++;
            end
            applyStimulus(1'b0, 4'b1111, d, {4'b0001 << mHold, mHold, 1'b1, 1'b0});
            e   = sb.pop_front();
            got = {grant, grant_id, busy, err};
            nChecks++;
            if (got !== e) begin
                nFails++;
                $display("[TB] FAIL round_robin[%0d]: got %b, expected %b", c, got, e);
            end
        end
        for (int i = 0; i < 5; i++) begin
            nChecks++;
            if (i >= order.size() || order[i] !== want[i]) begin
                nFails++;
                $display("[TB] FAIL rr_order[%0d]: got %0d, expected %0d", i,
                         (i < order.size()) ? order[i] : -1, want[i]);
            end
        end
        applyStimulus(1'b1, 4'b0000, 1'b0, '0);
        void'(sb.pop_front());
    endtask

    task automatic test_err_idle();
        stim_t tbl[6];
        exp_t  e;
        exp_t  got;
        tbl[0] = {1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1};
        tbl[1] = {1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[2] = {1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[3] = {1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[4] = {1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[5] = {1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].req, tbl[i].done, tbl[i].exp);
            e   = sb.pop_front();
            got = {grant, grant_id, busy, err};
            nChecks++;
            if (got !== e) begin
                nFails++;
                $display("[TB] FAIL err_idle[%0d]: got %b, expected %b", i, got, e);
            end
        end
    endtask

    task automatic test_hold_drop();
        stim_t tbl[9];
        exp_t  e;
        exp_t  got;
        tbl[0] = {1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        for (int i = 1; i < 7; i++) tbl[i] = {1'b0, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[7] = {1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[8] = {1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].req, tbl[i].done, tbl[i].exp);
            e   = sb.pop_front();
            got = {grant, grant_id, busy, err};
            nChecks++;
            if (got !== e) begin
                nFails++;
                $display("[TB] FAIL hold_drop[%0d]: got %b, expected %b", i, got, e);
            end
        end
    endtask

    task automatic test_long_hold();
        exp_t e;
        exp_t got;
        logic expErr;
        for (int j = 0; j <= 120; j++) begin
`ifdef ARB_TIMEOUT_EN
            expErr = (j > 0) && (j % 15 == 0);
`else
            expErr = 1'b0;
`endif
            applyStimulus(1'b0, 4'b0001, 1'b0, {4'b0001, 2'd0, 1'b1, expErr});
            e   = sb.pop_front();
            got = {grant, grant_id, busy, err};
            nChecks++;
            if (got !== e) begin
                nFails++;
                $display("[TB] FAIL long_hold[%0d]: got %b, expected %b", j, got, e);
            end
        end
        applyStimulus(1'b1, 4'b0000, 1'b0, '0);
        void'(sb.pop_front());
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_pattern();
        test_round_robin();
        test_err_idle();
        test_hold_drop();
        test_long_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule : tb_rr_arbiter_4
